// File: rtl/multi_charge_controller.sv
// multi_charge_controller: shared keypad front-end for NUM_CH charging ports,
// each with its own countdown timer, plus a common inactivity timeout.
module multi_charge_controller #(
  parameter int NUM_CH     = 4,
  parameter int MAX_MONEY  = 20,
  parameter int MAX_DIGITS = 2,
  parameter int RATE       = 2,
  parameter int NUM_DIV    = 1000,
  parameter int IDLE_SEC   = 10,
  parameter int MW         = 5,
  parameter int TW         = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           key_value,
  input  logic                 press,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 confirm,
  output logic                 no_display,
  output logic [1:0]           current_state,
  output logic [3:0]           sel_ch,
  output logic [MW-1:0]        disp_money,
  output logic [TW-1:0]        disp_time,
  output logic [NUM_CH-1:0]    busy,
  output logic [NUM_CH*TW-1:0] remaining_time,
  output logic                 err
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEL  = 2'd1,
    S_ENT  = 2'd2
  } state_t;

  localparam int DW = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1;
  localparam int IW = $clog2(IDLE_SEC + 1);
  localparam int GW = $clog2(MAX_DIGITS + 1);

  state_t                    state_q, state_d;
  logic [3:0]                sel_q, sel_d;
  logic [MW-1:0]             money_q, money_d;
  logic [GW-1:0]             dig_q, dig_d;
  logic [IW-1:0]             inact_q, inact_d;
  logic [DW-1:0]             div_q;
  logic                      err_q, err_d;
  logic                      prs_q, clr_q, sta_q, cfm_q;
  logic [NUM_CH-1:0][TW-1:0] rem_q, rem_d;
  logic [NUM_CH-1:0]         busy_q, busy_d;

  logic        tick, load, key_busy;
  logic        e_prs, e_clr, e_sta, e_cfm;
  logic        ev_clr, ev_cfm, ev_prs, ev_sta, any_ev;
  logic [31:0] acc;
  logic [TW-1:0] load_val, sel_time;

  assign tick   = (div_q == DW'(NUM_DIV - 1));
  assign e_prs  = press & ~prs_q;
  assign e_clr  = clear & ~clr_q;
  assign e_sta  = start & ~sta_q;
  assign e_cfm  = confirm & ~cfm_q;
  assign ev_clr = e_clr;
  assign ev_cfm = e_cfm & ~e_clr;
  assign ev_prs = e_prs & ~e_clr & ~e_cfm;
  assign ev_sta = e_sta & ~e_clr & ~e_cfm & ~e_prs;
  assign any_ev = e_clr | e_cfm | e_prs | e_sta;

  assign acc      = 32'(money_q) * 10 + 32'(key_value);
  assign load_val = TW'(32'(money_q) * RATE);

  always_comb begin
    // keys outside the port range read as unavailable
    key_busy = 1'b1;
    sel_time = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (key_value == 4'(i)) key_busy = busy_q[i];
      if (sel_q == 4'(i)) sel_time = rem_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    money_d = money_q;
    dig_d   = dig_q;
    inact_d = inact_q;
    err_d   = 1'b0;
    load    = 1'b0;
    if (state_q != S_IDLE) begin
      if (any_ev) begin
        inact_d = '0;
      end else if (tick) begin
        if (inact_q == IW'(IDLE_SEC - 1)) begin
          state_d = S_IDLE;
          money_d = '0;
          dig_d   = '0;
          inact_d = '0;
        end else begin
          inact_d = inact_q + 1'b1;
        end
      end
    end
    unique case (state_q)
      S_IDLE: begin
        inact_d = '0;
        if (ev_sta) state_d = S_SEL;
      end
      S_SEL: begin
        if (ev_prs) begin
          if (key_busy) begin
            err_d = 1'b1;
          end else begin
            sel_d   = key_value;
            money_d = '0;
            dig_d   = '0;
            state_d = S_ENT;
          end
        end
      end
      S_ENT: begin
        unique case (1'b1)
          ev_clr: begin
            money_d = '0;
            dig_d   = '0;
          end
          ev_cfm: begin
            if (money_q == '0) begin
              err_d = 1'b1;
            end else begin
              load    = 1'b1;
              money_d = '0;
              dig_d   = '0;
              state_d = S_SEL;
            end
          end
          ev_prs: begin
            if (key_value <= 4'd9 && dig_q < GW'(MAX_DIGITS)) begin
              money_d = (acc > MAX_MONEY) ? MW'(MAX_MONEY) : MW'(acc);
              dig_d   = dig_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          ev_sta: begin
            money_d = '0;
            dig_d   = '0;
            state_d = S_SEL;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // a load on the same cycle as a tick takes precedence over the decrement
  always_comb begin
    rem_d  = rem_q;
    busy_d = busy_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load && sel_q == 4'(i)) begin
        rem_d[i]  = load_val;
        busy_d[i] = 1'b1;
      end else if (tick && busy_q[i]) begin
        rem_d[i] = rem_q[i] - 1'b1;
        if (rem_q[i] == TW'(1)) busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      money_q <= '0;
      dig_q   <= '0;
      inact_q <= '0;
      div_q   <= '0;
      err_q   <= 1'b0;
      prs_q   <= 1'b0;
      clr_q   <= 1'b0;
      sta_q   <= 1'b0;
      cfm_q   <= 1'b0;
      rem_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      money_q <= money_d;
      dig_q   <= dig_d;
      inact_q <= inact_d;
      div_q   <= tick ? '0 : div_q + 1'b1;
      err_q   <= err_d;
      prs_q   <= press;
      clr_q   <= clear;
      sta_q   <= start;
      cfm_q   <= confirm;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
    end
  end

  assign no_display     = (state_q == S_IDLE);
  assign current_state  = state_q;
  assign sel_ch         = sel_q;
  assign disp_money     = money_q;
  assign disp_time      = sel_time;
  assign busy           = busy_q;
  assign remaining_time = rem_q;
  assign err            = err_q;
endmodule

// File: tb/tb_multi_charge_controller.sv
// Bench for multi_charge_controller: per-cycle expected outputs from a
// behavioural model are queued and compared by an independent monitor.
`timescale 1ns/1ps
module tb_multi_charge_controller;
  localparam int NUM_CH     = 4;
  localparam int MAX_MONEY  = 20;
  localparam int MAX_DIGITS = 2;
  localparam int RATE       = 2;
  localparam int NUM_DIV    = 8;
  localparam int IDLE_SEC   = 10;
  localparam int MW         = 5;
  localparam int TW         = 6;

  localparam int EV_NONE = 0;
  localparam int EV_CLR  = 1;
  localparam int EV_CFM  = 2;
  localparam int EV_PRS  = 3;
  localparam int EV_STA  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [3:0]           key_value = '0;
  logic                 press = 1'b0;
  logic                 clear = 1'b0;
  logic                 start = 1'b0;
  logic                 confirm = 1'b0;
  logic                 no_display;
  logic [1:0]           current_state;
  logic [3:0]           sel_ch;
  logic [MW-1:0]        disp_money;
  logic [TW-1:0]        disp_time;
  logic [NUM_CH-1:0]    busy;
  logic [NUM_CH*TW-1:0] remaining_time;
  logic                 err;

  multi_charge_controller #(
    .NUM_CH(NUM_CH), .MAX_MONEY(MAX_MONEY), .MAX_DIGITS(MAX_DIGITS),
    .RATE(RATE), .NUM_DIV(NUM_DIV), .IDLE_SEC(IDLE_SEC), .MW(MW), .TW(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_value(key_value), .press(press),
    .clear(clear), .start(start), .confirm(confirm),
    .no_display(no_display), .current_state(current_state),
    .sel_ch(sel_ch), .disp_money(disp_money), .disp_time(disp_time),
    .busy(busy), .remaining_time(remaining_time), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int sel;
    int money;
    int dt;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH*TW-1:0] rem;
    bit err;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  int m_st, m_sel, m_money, m_dig, m_inact, m_cyc;
  int m_rem[NUM_CH];
  bit m_err, pv_p, pv_c, pv_s, pv_f;

  function automatic void model(bit r, int k, bit p, bit c, bit s, bit f);
    bit ep, ec, es, ef, tk;
    int ev, ld, v;
    if (r) begin
      m_st = 0; m_sel = 0; m_money = 0; m_dig = 0; m_inact = 0;
      m_cyc = 0; m_err = 0;
      pv_p = 0; pv_c = 0; pv_s = 0; pv_f = 0;
      for (int i = 0; i < NUM_CH; i++) m_rem[i] = 0;
      return;
    end
    ep = p && !pv_p; ec = c && !pv_c; es = s && !pv_s; ef = f && !pv_f;
    pv_p = p; pv_c = c; pv_s = s; pv_f = f;
    tk = (m_cyc % NUM_DIV) == NUM_DIV - 1;
    m_cyc++;
    ev = ec ? EV_CLR : ef ? EV_CFM : ep ? EV_PRS : es ? EV_STA : EV_NONE;
    ld = -1;
    m_err = 0;
    if (m_st != 0) begin
      if (ev != EV_NONE) m_inact = 0;
      else if (tk) begin
        m_inact++;
        if (m_inact == IDLE_SEC) begin
          m_st = 0; m_money = 0; m_dig = 0; m_inact = 0;
        end
      end
    end
    case (m_st)
      0: if (ev == EV_STA) m_st = 1;
      1: if (ev == EV_PRS) begin
        if (k < NUM_CH && m_rem[k] == 0) begin
          m_sel = k; m_money = 0; m_dig = 0; m_st = 2;
        end else m_err = 1;
      end
      default: begin
        case (ev)
          EV_CLR: begin m_money = 0; m_dig = 0; end
          EV_CFM: begin
            if (m_money == 0) m_err = 1;
            else begin
              ld = m_money * RATE; m_money = 0; m_dig = 0; m_st = 1;
            end
          end
          EV_PRS: begin
            if (k <= 9 && m_dig < MAX_DIGITS) begin
              v = m_money * 10 + k;
              m_money = (v > MAX_MONEY) ? MAX_MONEY : v;
              m_dig++;
            end else m_err = 1;
          end
          EV_STA: begin m_money = 0; m_dig = 0; m_st = 1; end
          default: ;
        endcase
      end
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (ld >= 0 && i == m_sel) m_rem[i] = ld;
      else if (tk && m_rem[i] > 0) m_rem[i]--;
    end
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.st = m_st; e.sel = m_sel; e.money = m_money; e.err = m_err;
    e.dt = m_rem[m_sel];
    for (int i = 0; i < NUM_CH; i++) begin
      e.busy[i] = m_rem[i] > 0;
      e.rem[i*TW +: TW] = TW'(m_rem[i]);
    end
    return e;
  endfunction

  task automatic cyc(bit r, int k, bit p, bit c, bit s, bit f);
    rst_n = r; key_value = 4'(k);
    press = p; clear = c; start = s; confirm = f;
    model(r, k, p, c, s, f);
    sbq.push_back(snap());
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic key(int k);
    cyc(0, k, 1, 0, 0, 0);
    cyc(0, k, 0, 0, 0, 0);
  endtask

  task automatic b_start();
    cyc(0, 0, 0, 0, 1, 0); idle(1);
  endtask

  task automatic b_confirm();
    cyc(0, 0, 0, 0, 0, 1); idle(1);
  endtask

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty @%0t: got 0 entries expected 1", $time);
      end else begin
        e = sbq.pop_front();
        chk("state", current_state, e.st);
        chk("no_display", no_display, e.st == 0);
        chk("sel_ch", sel_ch, e.sel);
        chk("disp_money", disp_money, e.money);
        chk("disp_time", disp_time, e.dt);
        chk("busy", busy, e.busy);
        chk("remaining_time", remaining_time, e.rem);
        chk("err", err, e.err);
      end
    end
  end

  initial begin : stim
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);
    // port 1: 1,2 then a rejected third digit, load 24, run down
    b_start(); key(1); key(1); key(2); key(5); b_confirm();
    idle(25 * NUM_DIV);
    // saturation on port 0
    b_start(); key(0); key(9); key(9); b_confirm();
    // busy and out-of-range selections
    key(2); key(4); b_confirm();
    key(2); key(7);
    // inactivity timeout in ENTRY
    b_start(); key(3); key(5);
    idle(11 * NUM_DIV);
    // confirm coinciding with a tick
    cyc(1, 0, 0, 0, 0, 0);
    b_start(); key(0); key(5); b_confirm();
    key(1); key(3);
    for (int i = 0; i < NUM_DIV && (m_cyc % NUM_DIV) != NUM_DIV - 1; i++)
      idle(1);
    cyc(0, 0, 0, 0, 0, 1);
    idle(3);
    // reset mid-charge
    key(1); key(4); b_confirm();
    cyc(1, 0, 0, 0, 0, 0);
    idle(3);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int k;
      k = ($urandom_range(0, 1) == 1) ? $urandom_range(0, NUM_CH - 1)
                                      : $urandom_range(0, 15);
      cyc($urandom_range(0, 999) == 0, k, $urandom_range(0, 3) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 7) == 0);
      if (n % 500 == 499) idle(12 * NUM_DIV);
    end
    idle(2);
    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d entries expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
